// File: rtl/uart_link_pkg.sv
// Shared types and constants for the COREUART host-side link sequencer.
package uart_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_CAP,
    ST_RD_WAIT,
    ST_GUARD
  } state_e;

  localparam int ERR_OVF = 2;
  localparam int ERR_FRM = 1;
  localparam int ERR_PAR = 0;

  localparam logic [12:0] BAUD_RST       = 13'd0;
  localparam logic        BIT8_RST       = 1'b1;
  localparam logic        PARITY_EN_RST  = 1'b0;
  localparam logic        ODD_N_EVEN_RST = 1'b0;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_link_arb.sv
// Two-requester alternating arbiter; on a tie the requester not served last wins.
module uart_link_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_req,
  input  logic wr_req,
  input  logic take,
  output logic gnt_rd,
  output logic gnt_wr
);

  logic last_rd_q, last_rd_d;

  always_comb begin
    gnt_rd    = rd_req && (!wr_req || !last_rd_q);
    gnt_wr    = wr_req && (!rd_req || last_rd_q);
    last_rd_d = last_rd_q;
    if (take && gnt_rd)
      last_rd_d = 1'b1;
    else if (take && gnt_wr)
      last_rd_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_rd_q <= 1'b0;
    else
      last_rd_q <= last_rd_d;
  end

endmodule

// File: rtl/uart_link_ctrl.sv
// Sequences TX writes and RX reads onto the COREUART CSN/WEN/OEN strobe bus.
// Optional error counters are enabled with `define UART_LINK_ERR_CNT_EN.
//
// state      | meaning
// IDLE       | config loads, arbitrate rd/wr requests
// WR         | csn/wen low, byte presented, tx_ready high
// RD         | csn/oen low
// RD_CAP     | capture DATA_OUT and error flags into holding register
// RD_WAIT    | wait for RXRDY low or WAIT_MAX timeout
// GUARD      | GUARD_CYC quiet cycles before trusting RXRDY/TXRDY
module uart_link_ctrl
  import uart_link_pkg::*;
#(
  parameter int GUARD_CYC = 2,
  parameter int WAIT_MAX  = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [12:0] cfg_baud_val,
  input  logic        cfg_bit8,
  input  logic        cfg_parity_en,
  input  logic        cfg_odd_n_even,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic [2:0]  rx_err,
  input  logic        rx_ready,
  output logic        uart_csn,
  output logic        uart_wen,
  output logic        uart_oen,
  output logic [7:0]  uart_data_in,
  input  logic [7:0]  uart_data_out,
  input  logic        uart_txrdy,
  input  logic        uart_rxrdy,
  input  logic        uart_parity_err,
  input  logic        uart_framing_err,
  input  logic        uart_overflow,
  output logic [12:0] uart_baud_val,
  output logic        uart_bit8,
  output logic        uart_parity_en,
  output logic        uart_odd_n_even,
  output logic        busy
`ifdef UART_LINK_ERR_CNT_EN
  ,
  input  logic        err_clr,
  output logic [23:0] err_cnt
`endif
);

  localparam logic [7:0] GUARD_LD = 8'(GUARD_CYC - 1);
  localparam logic [7:0] WAIT_LD  = 8'(WAIT_MAX - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        csn_q, csn_d, wen_q, wen_d, oen_q, oen_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        tx_ready_q, tx_ready_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [2:0]  rx_err_q, rx_err_d;
  logic        busy_q, busy_d;
  logic [12:0] baud_q, baud_d;
  logic        bit8_q, bit8_d, par_en_q, par_en_d, odd_q, odd_d;
  logic        rd_req, wr_req, gnt_rd, gnt_wr, in_idle;

  assign in_idle = (state_q == ST_IDLE);
  assign rd_req  = uart_rxrdy && !rx_valid_q;
  assign wr_req  = tx_valid && uart_txrdy;

  uart_link_arb u_arb (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .take   (in_idle),
    .gnt_rd (gnt_rd),
    .gnt_wr (gnt_wr)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    csn_d      = 1'b1;
    wen_d      = 1'b1;
    oen_d      = 1'b1;
    data_in_d  = data_in_q;
    tx_ready_d = 1'b0;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_err_d   = rx_err_q;
    baud_d     = baud_q;
    bit8_d     = bit8_q;
    par_en_d   = par_en_q;
    odd_d      = odd_q;

    if (rx_valid_q && rx_ready)
      rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d   = cfg_baud_val;
        bit8_d   = cfg_bit8;
        par_en_d = cfg_parity_en;
        odd_d    = cfg_odd_n_even;
        // Strobes are registered, so they are set up on the grant edge.
        if (gnt_rd) begin
          state_d = ST_RD;
          csn_d   = 1'b0;
          oen_d   = 1'b0;
        end else if (gnt_wr) begin
          state_d    = ST_WR;
          csn_d      = 1'b0;
          wen_d      = 1'b0;
          data_in_d  = tx_data;
          tx_ready_d = 1'b1;
        end
      end
      ST_WR: begin
        state_d = ST_GUARD;
        cnt_d   = GUARD_LD;
      end
      ST_RD: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        rx_data_d           = uart_data_out;
        rx_err_d[ERR_OVF]   = uart_overflow;
        rx_err_d[ERR_FRM]   = uart_framing_err;
        rx_err_d[ERR_PAR]   = uart_parity_err;
        rx_valid_d          = 1'b1;
        state_d             = ST_RD_WAIT;
        cnt_d               = WAIT_LD;
      end
      ST_RD_WAIT: begin
        if (!uart_rxrdy || cnt_q == 8'd0) begin
          state_d = ST_GUARD;
          cnt_d   = GUARD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == 8'd0)
          state_d = ST_IDLE;
        else
          cnt_d = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      csn_q      <= 1'b1;
      wen_q      <= 1'b1;
      oen_q      <= 1'b1;
      data_in_q  <= 8'd0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_err_q   <= 3'd0;
      busy_q     <= 1'b0;
      baud_q     <= BAUD_RST;
      bit8_q     <= BIT8_RST;
      par_en_q   <= PARITY_EN_RST;
      odd_q      <= ODD_N_EVEN_RST;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      csn_q      <= csn_d;
      wen_q      <= wen_d;
      oen_q      <= oen_d;
      data_in_q  <= data_in_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
      busy_q     <= busy_d;
      baud_q     <= baud_d;
      bit8_q     <= bit8_d;
      par_en_q   <= par_en_d;
      odd_q      <= odd_d;
    end
  end

  assign uart_csn        = csn_q;
  assign uart_wen        = wen_q;
  assign uart_oen        = oen_q;
  assign uart_data_in    = data_in_q;
  assign tx_ready        = tx_ready_q;
  assign rx_valid        = rx_valid_q;
  assign rx_data         = rx_data_q;
  assign rx_err          = rx_err_q;
  assign busy            = busy_q;
  assign uart_baud_val   = baud_q;
  assign uart_bit8       = bit8_q;
  assign uart_parity_en  = par_en_q;
  assign uart_odd_n_even = odd_q;

`ifdef UART_LINK_ERR_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d, frm_cnt_q, frm_cnt_d, par_cnt_q, par_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    frm_cnt_d = frm_cnt_q;
    par_cnt_d = par_cnt_q;
    if (err_clr) begin
      ovf_cnt_d = 8'd0;
      frm_cnt_d = 8'd0;
      par_cnt_d = 8'd0;
    end else if (state_q == ST_RD_CAP) begin
      if (uart_overflow)    ovf_cnt_d = sat_inc(ovf_cnt_q);
      if (uart_framing_err) frm_cnt_d = sat_inc(frm_cnt_q);
      if (uart_parity_err)  par_cnt_d = sat_inc(par_cnt_q);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_cnt_q <= 8'd0;
      frm_cnt_q <= 8'd0;
      par_cnt_q <= 8'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      par_cnt_q <= par_cnt_d;
    end
  end

  assign err_cnt = {ovf_cnt_q, frm_cnt_q, par_cnt_q};
`endif

endmodule

// File: doc/uart_link_ctrl.md
Name: uart_link_ctrl

Overview:
- Host-side sequencer for the COREUART wrapper (no FIFOs, legacy-mode off).
- Turns a valid/ready TX byte stream and a valid/ready RX byte stream into the UART's shared CSN/WEN/OEN strobe bus.
- Arbitrates between TX writes and RX reads, and drives the static configuration pins.
- Sits between fabric logic and the UART, both clocked on CLK.

Parameters:
- GUARD_CYC, 2: minimum idle cycles after each strobe before RXRDY/TXRDY are trusted again (range 1..15).
- WAIT_MAX, 8: RD_WAIT timeout in cycles before returning to IDLE (range 2..255).

Ports:
- CLK  in  1  single system clock
- RESET_N  in  1  asynchronous active-low reset
- cfg_baud_val  in  13  baud divisor
- cfg_bit8  in  1  8-bit/7-bit select
- cfg_parity_en  in  1  parity enable
- cfg_odd_n_even  in  1  parity sense
- tx_valid  in  1  TX byte offered
- tx_data  in  8  TX byte
- tx_ready  out  1  TX byte accepted this cycle
- rx_valid  out  1  RX byte held
- rx_data  out  8  RX byte
- rx_err  out  3  {overflow, framing, parity} captured with rx_data
- rx_ready  in  1  consumer takes RX byte
- uart_csn  out  1  to CSN
- uart_wen  out  1  to WEN
- uart_oen  out  1  to OEN
- uart_data_in  out  8  to DATA_IN
- uart_data_out  in  8  from DATA_OUT
- uart_txrdy  in  1  from TXRDY
- uart_rxrdy  in  1  from RXRDY
- uart_parity_err  in  1  from PARITY_ERR
- uart_framing_err  in  1  from FRAMING_ERR
- uart_overflow  in  1  from OVERFLOW
- uart_baud_val  out  13  to BAUD_VAL
- uart_bit8  out  1  to BIT8
- uart_parity_en  out  1  to PARITY_EN
- uart_odd_n_even  out  1  to ODD_N_EVEN
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset:
  - One clock, CLK. Reset RESET_N is asynchronous, active-low.
  - Reset values: uart_csn=1, uart_wen=1, uart_oen=1, uart_data_in=0, tx_ready=0, rx_valid=0, rx_data=0, rx_err=0, busy=0.
  - Reset values of config outputs: baud=0, uart_bit8=1, uart_parity_en=0, uart_odd_n_even=0.
- Config outputs are registered and load from the cfg_* inputs only while the FSM is in IDLE. A change made while busy takes effect at the next IDLE cycle.
- FSM states: IDLE, WR, RD, RD_CAP, RD_WAIT, GUARD.
- IDLE arbitration:
  - rd_req = uart_rxrdy && !rx_valid.
  - wr_req = tx_valid && uart_txrdy.
  - If both are requested, the grant goes to the one not granted last (last_rd flag, reset=0, so RX wins the first tie).
  - If only one is requested, it is granted.
- WR (1 cycle):
  - Drive csn=0, wen=0, uart_data_in=tx_data, tx_ready=1.
  - Then go to GUARD.
  - tx_ready is high only in this cycle.
- RD (1 cycle):
  - Drive csn=0, oen=0.
  - Go to RD_CAP.
- RD_CAP:
  - Strobes deasserted.
  - rx_data <= uart_data_out.
  - rx_err <= {uart_overflow, uart_framing_err, uart_parity_err}.
  - rx_valid <= 1.
  - Go to RD_WAIT.
- RD_WAIT:
  - Wait for uart_rxrdy=0, or for WAIT_MAX cycles to elapse, whichever comes first.
  - Then go to GUARD.
- GUARD:
  - Count GUARD_CYC cycles, then go to IDLE.
  - Strobes stay deasserted.
- Latency:
  - TX: accept to WEN strobe is 1 cycle after IDLE grant.
  - RX: RXRDY to rx_valid is 3 cycles (IDLE, RD, RD_CAP) when uncontended.
- RX holding register:
  - Cleared when rx_valid && rx_ready.
  - A new read is never issued while rx_valid=1. Backpressure can therefore cause a UART overflow, which is reported in rx_err[2] of the next byte.
- Strobe rule: wen and oen are never low together; csn is low only in WR or RD.
- Reset mid-operation: all strobes return high immediately and asynchronously, and any in-flight byte is dropped.

Optional Feature:
- Macro: UART_LINK_ERR_CNT_EN.
- Defined:
  - Adds input err_clr (1) and output err_cnt (24) = {ovf[7:0], frm[7:0], par[7:0]}.
  - Each counter is an 8-bit saturating counter (sticks at 255), incremented in RD_CAP when the matching error bit is 1.
  - err_clr zeroes all three counters synchronously; if err_clr and an increment occur in the same cycle, clear wins.
  - All counters reset to 0.
- Undefined: those ports and counters are absent.

Decomposition:
- Shared package uart_link_pkg holds:
  - state enum;
  - ERR_OVF/ERR_FRM/ERR_PAR bit indices;
  - reset constants for the config outputs.
- One natural sub-module, uart_link_arb: the two-requester alternating arbiter with its last_rd flag.

Test Plan:
- TX single: tx_valid=1, tx_data=0xA5, txrdy=1 → exactly one cycle with csn=0, wen=0, uart_data_in=0xA5, tx_ready=1; then GUARD_CYC idle cycles.
- RX single: rxrdy rises, data_out=0x3C, no errors → one oen pulse; rx_valid=1, rx_data=0x3C, rx_err=0 three cycles later; rx_ready=1 clears it.
- Contention: tx_valid and rxrdy held high for 4 transfers → grant order RD, WR, RD, WR; wen/oen never low in the same cycle.
- Backpressure: rx_ready=0 with a second byte arriving and data_out=0x11, overflow=1 → no second oen until consumed; next byte has rx_err=3'b100.
- Reset mid-WR: RESET_N low during WR → csn/wen high the same cycle; after release busy=0, tx_ready=0, config outputs at reset values.
- Error counters (with UART_LINK_ERR_CNT_EN): 300 bytes with parity_err=1 → par saturates at 255; err_clr → err_cnt=0.
